mac_rr_arbiter: RTL and testbench

//   Shares one 4-bit MAC datapath between two requesters using round-robin arbitration.

---
 rtl/mac_rr_arbiter_if.sv | 39 +++
 rtl/mac_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mac_rr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rr_arbiter_if.sv
// Requester, MAC and response signals of the shared-MAC round-robin arbiter.
// The arbiter connects through the master modport; the surrounding logic uses slave.
interface mac_rr_arbiter_if #(
    parameter int DW = 4,
    parameter int OW = 10
);
    logic          req0_valid;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          req1_ready;
    logic          mac_in_valid;
    logic [DW-1:0] mac_in1;
    logic [DW-1:0] mac_in2;
    logic          mac_out_valid;
    logic [OW-1:0] mac_out;
    logic          rsp_valid;
    logic          rsp_id;
    logic [OW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    modport master (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  mac_out_valid, mac_out,
        output req0_ready, req1_ready, mac_in_valid, mac_in1, mac_in2,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output mac_out_valid, mac_out,
        input  req0_ready, req1_ready, mac_in_valid, mac_in1, mac_in2,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter sharing one MAC between two requesters, one job in flight,
// with a WAIT timeout that turns a silent MAC into an error response.
module mac_rr_arbiter #(
    parameter int DW      = 4,
    parameter int OW      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_rr_arbiter_if.master  bus
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          id_q, id_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mac_in_valid_q, mac_in_valid_d;
    logic [DW-1:0] mac_in1_q, mac_in1_d;
    logic [DW-1:0] mac_in2_q, mac_in2_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [OW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic idle;
    logic grant0, grant1;
    logic timer_last;

    assign idle       = (state_q == S_IDLE);
    // A lone valid requester wins outright; rr_ptr only breaks ties.
    assign grant0     = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
    assign grant1     = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
    assign timer_last = (timer_q == TW'(TIMEOUT - 1));

    assign bus.req0_ready   = idle & grant0;
    assign bus.req1_ready   = idle & grant1;
    assign bus.mac_in_valid = mac_in_valid_q;
    assign bus.mac_in1      = mac_in1_q;
    assign bus.mac_in2      = mac_in2_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.busy         = ~idle;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no branch can infer a latch.
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        timer_d        = timer_q;
        mac_in_valid_d = 1'b0;
        mac_in1_d      = mac_in1_q;
        mac_in2_d      = mac_in2_q;
        rsp_valid_d    = 1'b0;
        rsp_id_d       = rsp_id_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    id_d           = grant1;
                    mac_in1_d      = grant1 ? bus.req1_a : bus.req0_a;
                    mac_in2_d      = grant1 ? bus.req1_b : bus.req0_b;
                    mac_in_valid_d = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final timer cycle still beats the timeout.
                if (bus.mac_out_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = bus.mac_out;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (timer_last) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                rsp_err_d = 1'b0;
                rr_ptr_d  = ~id_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: asynchronous active-low reset aborts any in-flight job straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= 1'b0;
            id_q           <= 1'b0;
            timer_q        <= '0;
            mac_in_valid_q <= 1'b0;
            mac_in1_q      <= '0;
            mac_in2_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            timer_q        <= timer_d;
            mac_in_valid_q <= mac_in_valid_d;
            mac_in1_q      <= mac_in1_d;
            mac_in2_q      <= mac_in2_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.req0_ready && bus.req1_ready));
    a_issue_in_issue : assert property (@(posedge clk) disable iff (!rst_n)
        mac_in_valid_q |-> (state_q == S_ISSUE));
endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Self-checking bench for mac_rr_arbiter: directed corner cases plus random traffic,
// checked by a scoreboard fed from a job-level model of arbitration, latency and timeout.
module tb_mac_rr_arbiter;
    localparam int DW    = 4;
    localparam int OW    = 10;
    localparam int TO    = 15;
    localparam int NEVER = 1000000;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            cyc;
        int            lat;
    } iss_t;

    typedef struct {
        bit            id;
        logic [OW-1:0] data;
        bit            err;
        int            cyc;
    } rsp_t;

    logic clk;
    logic rst_n;

    logic          req_valid [2];
    logic [DW-1:0] req_a     [2];
    logic [DW-1:0] req_b     [2];
    logic          mac_ov;
    logic [OW-1:0] mac_o;

    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   hs_cnt [2];
    iss_t iss_q[$];
    rsp_t exp_q[$];

    // Model state, owned by the monitor.
    bit            active;
    bit            pref;
    int            m_hs_cyc;
    int            m_rsp_cyc;
    int            fire_cyc;
    logic [OW-1:0] fire_data;
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;
    logic [OW-1:0] last_data;

    // Stimulus knobs: lat_mode 0 = fixed lat_fixed, 1 = random, 2 = MAC never answers.
    int lat_mode;
    int lat_fixed;
    bit spurious_en;

    mac_rr_arbiter_if #(.DW(DW), .OW(OW)) bus ();

    assign bus.req0_valid    = req_valid[0];
    assign bus.req0_a        = req_a[0];
    assign bus.req0_b        = req_b[0];
    assign bus.req1_valid    = req_valid[1];
    assign bus.req1_a        = req_a[1];
    assign bus.req1_b        = req_b[1];
    assign bus.mac_out_valid = mac_ov;
    assign bus.mac_out       = mac_o;

    mac_rr_arbiter #(.DW(DW), .OW(OW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event, required none (cycle %0d)", name, cyc);
    endtask

    function automatic int pick_lat();
        case (lat_mode)
            0:       return lat_fixed;
            1:       return int'($urandom_range(1, TO + 3));
            default: return NEVER;
        endcase
    endfunction

    // Monitor, MAC model and scoreboard; runs mid-cycle, away from the active edge.
    always @(negedge clk) begin : monitor
        iss_t it;
        rsp_t rt;
        bit   idle, g0, g1, v0, v1;
        int   id, lat;
        if (!rst_n) begin
            exp_q.delete();
            iss_q.delete();
            active    = 1'b0;
            pref      = 1'b0;
            fire_cyc  = -1;
            last_a    = '0;
            last_b    = '0;
            last_data = '0;
            mac_ov    = 1'b0;
        end else begin
            idle = !active || (cyc > m_rsp_cyc);
            v0   = req_valid[0];
            v1   = req_valid[1];
            g0   = v0 && (!v1 || !pref);
            g1   = v1 && (!v0 || pref);
            check("req0_ready", 32'(bus.req0_ready), 32'(idle && g0));
            check("req1_ready", 32'(bus.req1_ready), 32'(idle && g1));
            check("busy", 32'(bus.busy),
                  32'(active && (cyc > m_hs_cyc) && (cyc <= m_rsp_cyc)));

            mac_ov = (cyc == fire_cyc);
            mac_o  = fire_data;
            if (!mac_ov && spurious_en && idle && ($urandom_range(0, 2) == 0)) begin
                mac_ov = 1'b1;
                mac_o  = OW'($urandom);
            end

            if (bus.mac_in_valid) begin
                if (iss_q.size() == 0) begin
                    fail("unexpected_issue");
                end else begin
                    it = iss_q.pop_front();
                    check("issue_cycle", 32'(cyc), 32'(it.cyc));
                    check("mac_in1", 32'(bus.mac_in1), 32'(it.a));
                    check("mac_in2", 32'(bus.mac_in2), 32'(it.b));
                    last_a    = it.a;
                    last_b    = it.b;
                    fire_cyc  = (it.lat == NEVER) ? -1 : cyc + it.lat;
                    fire_data = OW'(it.a) * OW'(it.b);
                end
            end else begin
                check("mac_in1_hold", 32'(bus.mac_in1), 32'(last_a));
                check("mac_in2_hold", 32'(bus.mac_in2), 32'(last_b));
                if (iss_q.size() != 0 && iss_q[0].cyc < cyc) begin
                    check("missing_issue", 32'(0), 32'(1));
                    void'(iss_q.pop_front());
                end
            end

            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    rt = exp_q.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(rt.cyc));
                    check("rsp_id", 32'(bus.rsp_id), 32'(rt.id));
                    check("rsp_data", 32'(bus.rsp_data), 32'(rt.data));
                    check("rsp_err", 32'(bus.rsp_err), 32'(rt.err));
                    last_data = rt.data;
                end
            end else begin
                check("rsp_err_idle", 32'(bus.rsp_err), 32'(0));
                check("rsp_data_hold", 32'(bus.rsp_data), 32'(last_data));
                if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    check("missing_rsp", 32'(0), 32'(1));
                    void'(exp_q.pop_front());
                end
            end

            if (idle && (g0 || g1)) begin
                id        = g1 ? 1 : 0;
                lat       = pick_lat();
                m_hs_cyc  = cyc;
                m_rsp_cyc = cyc + 2 + ((lat > TO) ? TO : lat);
                active    = 1'b1;
                pref      = (id == 0);
                it.a   = req_a[id];
                it.b   = req_b[id];
                it.cyc = cyc + 1;
                it.lat = lat;
                iss_q.push_back(it);
                rt.id   = (id == 1);
                rt.err  = (lat > TO);
                rt.data = rt.err ? '0 : OW'(it.a) * OW'(it.b);
                rt.cyc  = m_rsp_cyc;
                exp_q.push_back(rt);
                hs_cnt[id]++;
            end
        end
    end

    task automatic single_job(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int seen;
        bit got;
        seen          = hs_cnt[id];
        got           = 1'b0;
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (hs_cnt[id] != seen) got = 1'b1;
        end
        req_valid[id] = 1'b0;
        check("handshake_seen", 32'(got), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || iss_q.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("drain_in_budget", 32'(exp_q.size() + iss_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    // continuous = 1: both requesters always valid; else random raise/drop.
    task automatic run_stim(input int n, input bit continuous);
        int seen [2];
        for (int i = 0; i < 2; i++) seen[i] = hs_cnt[i];
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs_cnt[i] != seen[i]) begin
                    seen[i]      = hs_cnt[i];
                    req_valid[i] = 1'b0;
                end
                if (req_valid[i] && !continuous && $urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && (continuous || $urandom_range(0, 1) == 1)) begin
                    req_valid[i] = 1'b1;
                    req_a[i]     = DW'($urandom);
                    req_b[i]     = DW'($urandom);
                end
            end
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {7'd0, bus.req0_ready, bus.req1_ready, bus.mac_in_valid, bus.mac_in1,
                     bus.mac_in2, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
                     bus.busy}, 32'(0));
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        cyc          = 0;
        hs_cnt[0]    = 0;
        hs_cnt[1]    = 0;
        active       = 1'b0;
        pref         = 1'b0;
        m_hs_cyc     = 0;
        m_rsp_cyc    = 0;
        fire_cyc     = -1;
        fire_data    = '0;
        mac_ov       = 1'b0;
        mac_o        = '0;
        lat_mode     = 0;
        lat_fixed    = 4;
        spurious_en  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_a[i]     = '0;
            req_b[i]     = '0;
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_outputs");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single job with the team MAC latency.
        single_job(0, 4'd3, 4'd5);
        wait_idle(40);

        // Largest operands; spurious MAC strobes while idle must be ignored.
        spurious_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        single_job(1, 4'd15, 4'd15);
        wait_idle(40);
        repeat (6) @(posedge clk);
        #1;
        spurious_en = 1'b0;

        // MAC never answers: timeout error.
        lat_mode = 2;
        single_job(0, 4'd6, 4'd7);
        wait_idle(60);

        // One cycle past the timeout still errors; result on the last WAIT cycle wins.
        lat_mode  = 0;
        lat_fixed = TO + 1;
        single_job(1, 4'd2, 4'd11);
        wait_idle(60);
        lat_fixed = TO;
        single_job(0, 4'd7, 4'd9);
        wait_idle(60);

        // Reset while the job sits in WAIT.
        lat_mode = 2;
        single_job(0, 4'd9, 4'd6);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_wait");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both requesters always valid straight after reset.
        lat_mode  = 0;
        lat_fixed = 4;
        run_stim(30, 1'b1);
        wait_idle(40);

        // Random traffic, latencies around the timeout, spurious strobes.
        lat_mode    = 1;
        spurious_en = 1'b1;
        run_stim(600, 1'b0);
        spurious_en = 1'b0;
        wait_idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required completion by %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
